// File: rtl/udp_top_hls_deadlock_report_unit.sv
// Purpose : central deadlock report controller; collects unit detections, injects a
//           one-hot origin, follows the report token around the cycle, raises a report.
// Latency : origin one cycle after detection; report_valid one cycle after token returns.
// Backpr. : report held stable until report_ack; afterwards the unit parks in HOLD.
// Ports   : clock/reset (async, active-low); dl_detect_vec, proc_token_vec from units;
//           dl_detect_in, origin_vec, token_clear_vec to units; report_* to consumer.
module udp_top_hls_deadlock_report_unit #(
  parameter int PROC_NUM = 4,
  parameter int CNT_W    = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] proc_token_vec,
  output logic                dl_detect_in,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic [PROC_NUM-1:0] token_clear_vec,
  output logic                report_valid,
  input  logic                report_ack,
  output logic [PROC_NUM-1:0] report_origin,
  output logic [PROC_NUM-1:0] report_mask,
  output logic [CNT_W-1:0]    report_hops,
  output logic                report_timeout
);

  localparam int TMR_W = 16;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ORIGIN = 3'd1,
    S_TRACE  = 3'd2,
    S_REPORT = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PROC_NUM-1:0] org_q, org_d;
  logic [PROC_NUM-1:0] visited_q, visited_d;
  logic [CNT_W-1:0]    hops_q, hops_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                dl_detect_in_q, dl_detect_in_d;
  logic [PROC_NUM-1:0] origin_vec_q, origin_vec_d;
  logic                report_valid_q, report_valid_d;
  logic [PROC_NUM-1:0] report_origin_q, report_origin_d;
  logic [PROC_NUM-1:0] report_mask_q, report_mask_d;
  logic [CNT_W-1:0]    report_hops_q, report_hops_d;
  logic                report_timeout_q, report_timeout_d;

  logic [PROC_NUM-1:0] lowest_det;
  logic [PROC_NUM-1:0] new_vec;
  logic [PROC_NUM-1:0] visited_nxt;
  logic [CNT_W:0]      hop_sum;
  logic [CNT_W-1:0]    hops_nxt;
  logic                trace_done;

  // Two's-complement trick isolates the lowest set bit: lowest index wins ties.
  assign lowest_det = dl_detect_vec & (~dl_detect_vec + PROC_NUM'(1));

  // Processes reached by the token for the first time this cycle.
  assign new_vec     = proc_token_vec & ~visited_q;
  assign visited_nxt = visited_q | new_vec;

  always_comb begin
    hop_sum = {1'b0, hops_q};
    for (int i = 0; i < PROC_NUM; i++) begin
      hop_sum = hop_sum + {{CNT_W{1'b0}}, new_vec[i]};
    end
  end

  // Carry out of the hop adder means the counter would wrap; pin it at all-ones.
  assign hops_nxt   = hop_sum[CNT_W] ? {CNT_W{1'b1}} : hop_sum[CNT_W-1:0];
  assign trace_done = |(proc_token_vec & dl_detect_vec & org_q);

  always_comb begin
    state_d          = state_q;
    org_d            = org_q;
    visited_d        = visited_q;
    hops_d           = hops_q;
    timer_d          = timer_q;
    report_origin_d  = report_origin_q;
    report_mask_d    = report_mask_q;
    report_hops_d    = report_hops_q;
    report_timeout_d = report_timeout_q;
    token_clear_vec  = '0;

    case (state_q)
      S_IDLE: begin
        if (|dl_detect_vec) begin
          org_d   = lowest_det;
          state_d = S_ORIGIN;
        end
      end
      S_ORIGIN: begin
        // Token cannot have moved yet: units register it, so neighbours see it next cycle.
        visited_d = org_q;
        hops_d    = '0;
        timer_d   = '0;
        state_d   = S_TRACE;
      end
      S_TRACE: begin
        visited_d = visited_nxt;
        hops_d    = hops_nxt;
        timer_d   = timer_q + TMR_W'(1);
        // A returned token wins over a timeout landing on the same cycle.
        if (trace_done) begin
          token_clear_vec  = org_q;
          report_origin_d  = org_q;
          report_mask_d    = visited_nxt;
          report_hops_d    = hops_nxt;
          report_timeout_d = 1'b0;
          state_d          = S_REPORT;
        end else if (timer_q == TMR_LAST) begin
          report_origin_d  = org_q;
          report_mask_d    = visited_nxt;
          report_hops_d    = hops_nxt;
          report_timeout_d = 1'b1;
          state_d          = S_REPORT;
        end
      end
      S_REPORT: begin
        if (report_ack) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // Deadlock is terminal; only reset brings the controller back to IDLE.
        state_d = S_HOLD;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered outputs are decoded from the next state so they line up with it.
    dl_detect_in_d = (state_d != S_IDLE);
    origin_vec_d   = (state_d == S_ORIGIN) ? org_d : '0;
    report_valid_d = (state_d == S_REPORT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      org_q            <= '0;
      visited_q        <= '0;
      hops_q           <= '0;
      timer_q          <= '0;
      dl_detect_in_q   <= 1'b0;
      origin_vec_q     <= '0;
      report_valid_q   <= 1'b0;
      report_origin_q  <= '0;
      report_mask_q    <= '0;
      report_hops_q    <= '0;
      report_timeout_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      org_q            <= org_d;
      visited_q        <= visited_d;
      hops_q           <= hops_d;
      timer_q          <= timer_d;
      dl_detect_in_q   <= dl_detect_in_d;
      origin_vec_q     <= origin_vec_d;
      report_valid_q   <= report_valid_d;
      report_origin_q  <= report_origin_d;
      report_mask_q    <= report_mask_d;
      report_hops_q    <= report_hops_d;
      report_timeout_q <= report_timeout_d;
    end
  end

  assign dl_detect_in   = dl_detect_in_q;
  assign origin_vec     = origin_vec_q;
  assign report_valid   = report_valid_q;
  assign report_origin  = report_origin_q;
  assign report_mask    = report_mask_q;
  assign report_hops    = report_hops_q;
  assign report_timeout = report_timeout_q;

endmodule

// File: tb/tb_udp_top_hls_deadlock_report_unit.sv
// Purpose : directed self-checking bench for the deadlock report controller.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpr. : report_ack driven directly by the scenarios.
module tb_udp_top_hls_deadlock_report_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] dl_detect_vec;
  logic [3:0] proc_token_vec;
  logic       dl_detect_in;
  logic [3:0] origin_vec;
  logic [3:0] token_clear_vec;
  logic       report_valid;
  logic       report_ack;
  logic [3:0] report_origin;
  logic [3:0] report_mask;
  logic [7:0] report_hops;
  logic       report_timeout;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  udp_top_hls_deadlock_report_unit #(
    .PROC_NUM(4),
    .CNT_W   (8),
    .TIMEOUT (16)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .dl_detect_vec  (dl_detect_vec),
    .proc_token_vec (proc_token_vec),
    .dl_detect_in   (dl_detect_in),
    .origin_vec     (origin_vec),
    .token_clear_vec(token_clear_vec),
    .report_valid   (report_valid),
    .report_ack     (report_ack),
    .report_origin  (report_origin),
    .report_mask    (report_mask),
    .report_hops    (report_hops),
    .report_timeout (report_timeout)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    dl_detect_vec  = '0;
    proc_token_vec = '0;
    report_ack     = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset          = 1'b0;
    dl_detect_vec  = 4'b1111;
    proc_token_vec = 4'b1111;
    report_ack     = 1'b1;
    step();
    dl_detect_vec  = 4'b0101;
    step();
    total++; if (dl_detect_in !== 1'b0) $display("FAIL rst_dl_detect_in: got %b want 0", dl_detect_in); else passed++;
    total++; if (origin_vec !== 4'b0000) $display("FAIL rst_origin_vec: got %b want 0000", origin_vec); else passed++;
    total++; if (token_clear_vec !== 4'b0000) $display("FAIL rst_token_clear: got %b want 0000", token_clear_vec); else passed++;
    total++; if (report_valid !== 1'b0) $display("FAIL rst_report_valid: got %b want 0", report_valid); else passed++;
    total++; if ({report_origin, report_mask, report_hops, report_timeout} !== 17'd0)
      $display("FAIL rst_report_fields: got %b/%b/%0d/%b want all zero", report_origin, report_mask, report_hops, report_timeout);
    else passed++;
    dl_detect_vec  = '0;
    proc_token_vec = '0;
    report_ack     = 1'b0;
    reset          = 1'b1;
    step();
    step();
    total++; if (dl_detect_in !== 1'b0) $display("FAIL rst_release_idle: got %b want 0", dl_detect_in); else passed++;
  endtask

  task automatic test_three_cycle_loop();
    do_reset();
    dl_detect_vec = 4'b0010;
    step();  // ORIGIN
    total++; if (origin_vec !== 4'b0010) $display("FAIL loop_origin_pulse: got %b want 0010", origin_vec); else passed++;
    total++; if (dl_detect_in !== 1'b1) $display("FAIL loop_dl_in_origin: got %b want 1", dl_detect_in); else passed++;
    dl_detect_vec = 4'b0000;
    step();  // TRACE, timer 0
    total++; if (origin_vec !== 4'b0000) $display("FAIL loop_origin_drop: got %b want 0000", origin_vec); else passed++;
    total++; if (dl_detect_in !== 1'b1) $display("FAIL loop_dl_in_trace: got %b want 1", dl_detect_in); else passed++;
    proc_token_vec = 4'b0100;
    #1;
    total++; if (token_clear_vec !== 4'b0000) $display("FAIL loop_no_clear_hop1: got %b want 0000", token_clear_vec); else passed++;
    step();
    proc_token_vec = 4'b1000;
    step();
    proc_token_vec = 4'b0010;
    dl_detect_vec  = 4'b0010;
    #1;
    total++; if (token_clear_vec !== 4'b0010) $display("FAIL loop_token_clear: got %b want 0010", token_clear_vec); else passed++;
    total++; if (report_valid !== 1'b0) $display("FAIL loop_valid_early: got %b want 0", report_valid); else passed++;
    step();  // REPORT
    proc_token_vec = 4'b0000;
    dl_detect_vec  = 4'b0000;
    #1;
    total++; if (report_valid !== 1'b1) $display("FAIL loop_report_valid: got %b want 1", report_valid); else passed++;
    total++; if (report_origin !== 4'b0010) $display("FAIL loop_report_origin: got %b want 0010", report_origin); else passed++;
    total++; if (report_mask !== 4'b1110) $display("FAIL loop_report_mask: got %b want 1110", report_mask); else passed++;
    total++; if (report_hops !== 8'd2) $display("FAIL loop_report_hops: got %0d want 2", report_hops); else passed++;
    total++; if (report_timeout !== 1'b0) $display("FAIL loop_report_timeout: got %b want 0", report_timeout); else passed++;
    total++; if (token_clear_vec !== 4'b0000) $display("FAIL loop_clear_in_report: got %b want 0000", token_clear_vec); else passed++;
    report_ack = 1'b1;
    step();  // HOLD
    report_ack = 1'b0;
    total++; if (report_valid !== 1'b0) $display("FAIL loop_valid_after_ack: got %b want 0", report_valid); else passed++;
    total++; if (dl_detect_in !== 1'b1) $display("FAIL loop_dl_in_hold: got %b want 1", dl_detect_in); else passed++;
  endtask

  task automatic test_simultaneous_self_loop();
    do_reset();
    dl_detect_vec = 4'b1010;
    step();  // ORIGIN
    total++; if (origin_vec !== 4'b0010) $display("FAIL sim_origin_lowest: got %b want 0010", origin_vec); else passed++;
    dl_detect_vec = 4'b0000;
    step();  // TRACE: token immediately back at origin
    proc_token_vec = 4'b0010;
    dl_detect_vec  = 4'b0010;
    #1;
    total++; if (token_clear_vec !== 4'b0010) $display("FAIL self_token_clear: got %b want 0010", token_clear_vec); else passed++;
    step();
    proc_token_vec = 4'b0000;
    dl_detect_vec  = 4'b0000;
    total++; if (report_valid !== 1'b1) $display("FAIL self_report_valid: got %b want 1", report_valid); else passed++;
    total++; if (report_mask !== 4'b0010) $display("FAIL self_report_mask: got %b want 0010", report_mask); else passed++;
    total++; if (report_hops !== 8'd0) $display("FAIL self_report_hops: got %0d want 0", report_hops); else passed++;
    total++; if (report_origin !== 4'b0010) $display("FAIL self_report_origin: got %b want 0010", report_origin); else passed++;
    report_ack = 1'b1;
    step();
    report_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int  n;
    logic clr_seen;
    do_reset();
    dl_detect_vec = 4'b0100;
    step();  // ORIGIN
    dl_detect_vec  = 4'b0000;
    proc_token_vec = 4'b0001;
    n        = 0;
    clr_seen = 1'b0;
    while (report_valid !== 1'b1 && n < 40) begin
      if (token_clear_vec !== 4'b0000) clr_seen = 1'b1;
      step();
      n++;
    end
    proc_token_vec = 4'b0000;
    // One step ORIGIN->TRACE, then 16 TRACE cycles before REPORT.
    total++; if (n !== 17) $display("FAIL to_cycles: got %0d want 17", n); else passed++;
    total++; if (report_valid !== 1'b1) $display("FAIL to_report_valid: got %b want 1", report_valid); else passed++;
    total++; if (report_timeout !== 1'b1) $display("FAIL to_report_timeout: got %b want 1", report_timeout); else passed++;
    total++; if (report_mask !== 4'b0101) $display("FAIL to_report_mask: got %b want 0101", report_mask); else passed++;
    total++; if (report_hops !== 8'd1) $display("FAIL to_report_hops: got %0d want 1", report_hops); else passed++;
    total++; if (clr_seen !== 1'b0) $display("FAIL to_no_token_clear: got %b want 0", clr_seen); else passed++;
    report_ack = 1'b1;
    step();
    report_ack = 1'b0;
  endtask

  task automatic test_handshake();
    logic stable;
    do_reset();
    report_ack    = 1'b1;  // ignored outside REPORT
    dl_detect_vec = 4'b0100;
    step();  // ORIGIN
    report_ack    = 1'b0;
    dl_detect_vec = 4'b0000;
    step();  // TRACE
    proc_token_vec = 4'b1000;
    step();
    proc_token_vec = 4'b0100;
    dl_detect_vec  = 4'b0100;
    step();  // REPORT
    proc_token_vec = 4'b0000;
    dl_detect_vec  = 4'b0000;
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (report_valid !== 1'b1 || report_origin !== 4'b0100 || report_mask !== 4'b1100 ||
          report_hops !== 8'd1 || report_timeout !== 1'b0) stable = 1'b0;
      step();
    end
    total++; if (stable !== 1'b1)
      $display("FAIL hs_fields_stable: got %b/%b/%b/%0d/%b want 1/0100/1100/1/0", report_valid, report_origin, report_mask, report_hops, report_timeout);
    else passed++;
    total++; if (report_valid !== 1'b1) $display("FAIL hs_valid_held: got %b want 1", report_valid); else passed++;
    report_ack = 1'b1;
    step();  // HOLD
    report_ack = 1'b0;
    total++; if (report_valid !== 1'b0) $display("FAIL hs_valid_cleared: got %b want 0", report_valid); else passed++;
    total++; if (dl_detect_in !== 1'b1) $display("FAIL hs_dl_in_hold: got %b want 1", dl_detect_in); else passed++;
    dl_detect_vec = 4'b0001;
    stable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (origin_vec !== 4'b0000 || report_valid !== 1'b0 || dl_detect_in !== 1'b1) stable = 1'b0;
    end
    dl_detect_vec = 4'b0000;
    total++; if (stable !== 1'b1)
      $display("FAIL hs_no_new_origin: got origin %b valid %b dl_in %b want 0000/0/1", origin_vec, report_valid, dl_detect_in);
    else passed++;
  endtask

  task automatic test_mid_trace_reset();
    do_reset();
    dl_detect_vec = 4'b0001;
    step();  // ORIGIN
    dl_detect_vec = 4'b0000;
    step();  // TRACE
    proc_token_vec = 4'b0010;
    step();  // TRACE, one hop counted
    #4;
    reset = 1'b0;
    #1;
    total++; if (dl_detect_in !== 1'b0) $display("FAIL mr_dl_in_async: got %b want 0", dl_detect_in); else passed++;
    total++; if (token_clear_vec !== 4'b0000 || origin_vec !== 4'b0000 || report_valid !== 1'b0)
      $display("FAIL mr_outputs_async: got clr %b org %b vld %b want 0", token_clear_vec, origin_vec, report_valid);
    else passed++;
    proc_token_vec = 4'b0000;
    step();
    reset = 1'b1;
    step();
    dl_detect_vec = 4'b1000;
    step();  // ORIGIN
    total++; if (origin_vec !== 4'b1000) $display("FAIL mr_restart_origin: got %b want 1000", origin_vec); else passed++;
    dl_detect_vec = 4'b0000;
    step();  // TRACE
    proc_token_vec = 4'b1000;
    dl_detect_vec  = 4'b1000;
    step();  // REPORT
    proc_token_vec = 4'b0000;
    dl_detect_vec  = 4'b0000;
    total++; if (report_valid !== 1'b1) $display("FAIL mr_report_valid: got %b want 1", report_valid); else passed++;
    total++; if (report_hops !== 8'd0) $display("FAIL mr_report_hops: got %0d want 0", report_hops); else passed++;
    total++; if (report_mask !== 4'b1000) $display("FAIL mr_report_mask: got %b want 1000", report_mask); else passed++;
  endtask

  initial begin
    reset          = 1'b0;
    dl_detect_vec  = '0;
    proc_token_vec = '0;
    report_ack     = 1'b0;
    test_reset();
    test_three_cycle_loop();
    test_simultaneous_self_loop();
    test_timeout();
    test_handshake();
    test_mid_trace_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got %0d checks want completion", total);
    $fatal(1);
  end

endmodule

// File: doc/udp_top_hls_deadlock_report_unit.md
# udp_top_hls_deadlock_report_unit

Central controller for the per-process deadlock detection units in the UDP top HLS dataflow region. It collects every unit's `dl_detect_out` and broadcasts `dl_detect_in` once a deadlock is seen. It then injects a one-hot `origin` into exactly one unit and follows the report token around the dependence cycle. When the token returns to the origin, it clears the token and raises a report describing the cycle.

## Interface
Parameters:
- `PROC_NUM`, 4, number of processes/detection units.
- `CNT_W`, 8, width of hop counter.
- `TIMEOUT`, 1024, maximum cycles in TRACE before abort; must be < 2^16.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `dl_detect_vec`  in  PROC_NUM  bit i = `dl_detect_out` of unit i.
- `proc_token_vec`  in  PROC_NUM  bit i = OR of unit i's `token_in_vec`.
- `dl_detect_in`  out  1  broadcast to all units; registered.
- `origin_vec`  out  PROC_NUM  one-hot origin pulse; bit i drives unit i `origin`; registered.
- `token_clear_vec`  out  PROC_NUM  bit i drives unit i `token_clear`; combinational.
- `report_valid`  out  1  report available; registered.
- `report_ack`  in  1  consumer accepts report.
- `report_origin`  out  PROC_NUM  one-hot origin process.
- `report_mask`  out  PROC_NUM  processes visited by token, origin included.
- `report_hops`  out  CNT_W  token hop count, saturating.
- `report_timeout`  out  1  trace aborted by TIMEOUT.

## Operation
- FSM states: IDLE, ORIGIN, TRACE, REPORT, HOLD.
- **IDLE**
  - `dl_detect_in`=0.
  - If `|dl_detect_vec`: latch `org` = lowest-index set bit (one-hot), go ORIGIN.
- **ORIGIN** (exactly 1 cycle)
  - `origin_vec`=`org`, `dl_detect_in`=1.
  - visited=`org`, hops=0, timer=0. Go TRACE.
- **TRACE**
  - `dl_detect_in`=1, `origin_vec`=0.
  - Each cycle: new = `proc_token_vec` & ~visited; visited |= new; hops += popcount(new), saturating at 2^CNT_W-1; timer++.
  - Done when `proc_token_vec` & `dl_detect_vec` & `org` is nonzero. In that same cycle `token_clear_vec`=`org`; latch report with `report_timeout`=0; go REPORT.
  - Else if timer == TIMEOUT-1: latch report with `report_timeout`=1; go REPORT. No token_clear.
- **REPORT**
  - `report_valid`=1; report fields stable.
  - On `report_ack`: go HOLD.
- **HOLD**
  - `dl_detect_in` stays 1; no further origins.
  - Deadlock is terminal; only reset leaves HOLD.
- `token_clear_vec` is zero in every state except the done cycle of TRACE.
- `origin_vec` is never non-zero outside ORIGIN.
- Simultaneous detections: lowest index wins; others are ignored.
- A token seen at the origin before any other hop still completes the trace (self-loop, hops=0, mask=`org`).
- `dl_detect_vec` deasserting during TRACE has no effect.

## Timing
- Reset (async, active-low): state=IDLE; `dl_detect_in`=0, `origin_vec`=0, `report_valid`=0, all report fields 0, internal counters 0. Reset mid-operation aborts immediately.
- Detection sampled at edge t (dl_detect high in cycle t-1) → state ORIGIN during cycle t; `origin_vec` and `dl_detect_in` high in cycle t.
- Units register the token, so the origin's neighbours see the token from cycle t+1.
- Done cycle d: `token_clear_vec` asserted in cycle d combinationally; `report_valid` high from cycle d+1.
- `report_valid` is held until the cycle `report_ack` is sampled high. The transition to HOLD happens at that edge; `report_valid`=0 the next cycle.
- `report_ack` while not in REPORT: ignored.

## Test plan
- **Reset values.** Hold reset low, toggle inputs → all outputs 0. Release → IDLE, `dl_detect_in`=0.
- **3-cycle loop.** PROC_NUM=4; `dl_detect_vec`=0010 at cycle 0. Then `origin_vec`=0010 for one cycle and `dl_detect_in`=1 persists. Token sequence 0100, 1000, then 0010 with `dl_detect_vec`=0010 → `token_clear_vec`=0010 that cycle. Next cycle report: origin=0010, mask=1110, hops=2, timeout=0.
- **Simultaneous detect.** `dl_detect_vec`=1010 → `origin_vec`=0010 only.
- **Timeout.** TIMEOUT=16, tokens never return → `report_valid` after 16 TRACE cycles, `report_timeout`=1, `token_clear_vec` never asserted.
- **Handshake.** Delay `report_ack` 5 cycles → fields stable throughout; after ack `report_valid`=0, `dl_detect_in` stays 1. A later `dl_detect_vec` produces no origin.
- **Mid-trace reset.** Assert reset during TRACE → outputs 0 asynchronously. After release, a new detection restarts cleanly with hops=0.
